// File: rtl/vector_result_collector.sv
// Vector result collector: gathers per-lane element results into a VLEN-wide
// destination image (SEW slots or mask bits), applies v0 masking and
// tail-undisturbed policy, then hands the finished register to the VRF.
//
// Handshakes (valid/ready): a lane beat transfers on a rising edge where
// in_valid && in_ready; the destination transfers on a rising edge where
// out_valid && out_ack. Producers hold data stable while valid is high and
// ready/ack is low; the collector holds out_data stable while out_valid is high.
module vector_result_collector #(
  parameter int LONGEST_LEN     = 64,
  parameter int VECTOR_SIZE     = 8,
  parameter int VLEN            = VECTOR_SIZE * LONGEST_LEN,
  parameter int LANE_NUM        = 2,
  parameter int LANE_INDEX_SIZE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [31:0]                     vl,
  input  logic [2:0]                      vsew,
  input  logic                            is_mask_operation,
  input  logic                            vm,
  input  logic [VLEN-1:0]                 v0_mask,
  input  logic [VLEN-1:0]                 vd_old,
  input  logic                            in_valid,
  input  logic [LANE_NUM*LONGEST_LEN-1:0] in_result,
  output logic                            in_ready,
  output logic [31:0]                     elem_idx,
  output logic                            busy,
  output logic                            out_valid,
  output logic [VLEN-1:0]                 out_data,
  input  logic                            out_ack,
  output logic [1:0]                      state_dbg
);

  localparam logic [2:0] ONE_BYTE   = 3'd0;
  localparam logic [2:0] TWO_BYTE   = 3'd1;
  localparam logic [2:0] FOUR_BYTE  = 3'd2;
  localparam logic [2:0] EIGHT_BYTE = 3'd3;

  // Bit-index width inside the destination image.
  localparam int IW = $clog2(VLEN);
  // Elements advanced per accepted beat.
  localparam int unsigned LANE_STEP = 1 << LANE_INDEX_SIZE;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      cfg_sew;     // log2(SEW/8)
  logic            cfg_mask;
  logic            cfg_vm;
  logic [VLEN-1:0] cfg_v0;
  logic [31:0]     vl_eff;
  logic [VLEN-1:0] buffer;

  logic [1:0]      start_sew;
  logic [31:0]     start_vlmax;
  logic [31:0]     start_vl_eff;
  logic [VLEN-1:0] merged;
  logic            last_beat;

  logic [31:0]     lane_elem [LANE_NUM];
  logic            lane_we   [LANE_NUM];

  // Decode the requested SEW and clamp vl to VLMAX for the start transfer.
  always_comb begin
    start_sew = 2'd3;
    case (vsew)
      ONE_BYTE:   start_sew = 2'd0;
      TWO_BYTE:   start_sew = 2'd1;
      FOUR_BYTE:  start_sew = 2'd2;
      EIGHT_BYTE: start_sew = 2'd3;
      default:    start_sew = 2'd3;  // unknown encodings collect as 64-bit
    endcase
    start_vlmax  = is_mask_operation ? 32'(VLEN) : (32'(VLEN / 8) >> start_sew);
    start_vl_eff = (vl < start_vlmax) ? vl : start_vlmax;
  end

  // Per-lane element index and write permission (body element, not masked off).
  for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane
    assign lane_elem[g] = elem_idx + 32'(g);
    assign lane_we[g]   = (lane_elem[g] < vl_eff) &&
                          (cfg_vm || cfg_v0[lane_elem[g][IW-1:0]]);
  end

  // Merge the current beat into the image; disallowed slots keep old contents.
  always_comb begin
    merged = buffer;
    for (int k = 0; k < LANE_NUM; k++) begin
      if (lane_we[k]) begin
        if (cfg_mask) begin
          merged[lane_elem[k][IW-1:0]] = in_result[k*LONGEST_LEN];
        end else begin
          case (cfg_sew)
            2'd0: merged[{lane_elem[k][IW-4:0], 3'b000}    +: 8]  = in_result[k*LONGEST_LEN +: 8];
            2'd1: merged[{lane_elem[k][IW-5:0], 4'b0000}   +: 16] = in_result[k*LONGEST_LEN +: 16];
            2'd2: merged[{lane_elem[k][IW-6:0], 5'b00000}  +: 32] = in_result[k*LONGEST_LEN +: 32];
            default: merged[{lane_elem[k][IW-7:0], 6'b000000} +: 64] = in_result[k*LONGEST_LEN +: 64];
          endcase
        end
      end
    end
  end

  assign last_beat = (elem_idx + 32'(LANE_STEP)) >= vl_eff;

  // Collector FSM: latch config on start, merge beats, hold result until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cfg_sew  <= 2'd0;
      cfg_mask <= 1'b0;
      cfg_vm   <= 1'b0;
      cfg_v0   <= '0;
      vl_eff   <= 32'd0;
      buffer   <= '0;
      elem_idx <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_sew  <= start_sew;
            cfg_mask <= is_mask_operation;
            cfg_vm   <= vm;
            cfg_v0   <= v0_mask;
            vl_eff   <= start_vl_eff;
            buffer   <= vd_old;
            elem_idx <= 32'd0;
            state    <= (start_vl_eff == 32'd0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (in_valid) begin
            buffer   <= merged;
            elem_idx <= elem_idx + 32'(LANE_STEP);
            if (last_beat) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_COLLECT);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_data  = buffer;
  assign state_dbg = state;

endmodule

// File: tb/tb_vector_result_collector.sv
// Testbench for vector_result_collector: scenario tasks with a scoreboard of
// expected destination images built by an independent bit-level model.
module tb_vector_result_collector;

  localparam int VLEN = 512;
  localparam int LW   = 64;
  localparam int LN   = 2;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [31:0]     vl;
  logic [2:0]      vsew;
  logic            is_mask_operation;
  logic            vm;
  logic [VLEN-1:0] v0_mask;
  logic [VLEN-1:0] vd_old;
  logic            in_valid;
  logic [LN*LW-1:0] in_result;
  logic            in_ready;
  logic [31:0]     elem_idx;
  logic            busy;
  logic            out_valid;
  logic [VLEN-1:0] out_data;
  logic            out_ack;
  logic [1:0]      state_dbg;

  logic [VLEN-1:0] exp_q[$];
  logic [63:0]     res [0:64];
  int              n_checks;
  int              n_pass;

  vector_result_collector dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .vl                (vl),
    .vsew              (vsew),
    .is_mask_operation (is_mask_operation),
    .vm                (vm),
    .v0_mask           (v0_mask),
    .vd_old            (vd_old),
    .in_valid          (in_valid),
    .in_result         (in_result),
    .in_ready          (in_ready),
    .elem_idx          (elem_idx),
    .busy              (busy),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ack           (out_ack),
    .state_dbg         (state_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic int sew_bits(input logic [2:0] s);
    case (s)
      3'd0:    return 8;
      3'd1:    return 16;
      3'd2:    return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int model_vl_eff(input int vl_i, input logic [2:0] s, input logic msk);
    int vlmax;
    vlmax = msk ? VLEN : VLEN / sew_bits(s);
    return (vl_i < vlmax) ? vl_i : vlmax;
  endfunction

  function automatic logic [VLEN-1:0] model_image(input int vl_i, input logic [2:0] s,
      input logic msk, input logic vm_i, input logic [VLEN-1:0] v0, input logic [VLEN-1:0] vd);
    logic [VLEN-1:0] img;
    int vle, sb;
    img = vd;
    vle = model_vl_eff(vl_i, s, msk);
    sb  = sew_bits(s);
    for (int e = 0; e < vle; e++) begin
      if (vm_i || v0[e]) begin
        if (msk) img[e] = res[e][0];
        else for (int b = 0; b < sb; b++) img[e*sb + b] = res[e][b];
      end
    end
    return img;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic fill_random_res();
    for (int e = 0; e < 65; e++) res[e] = {$urandom, $urandom};
  endtask

  // ---------------- driver ----------------
  task automatic do_start(input int vl_i, input logic [2:0] s, input logic msk,
      input logic vm_i, input logic [VLEN-1:0] v0, input logic [VLEN-1:0] vd);
    vl = 32'(vl_i); vsew = s; is_mask_operation = msk; vm = vm_i;
    v0_mask = v0; vd_old = vd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vl = $urandom; vd_old = rand_vec(); v0_mask = rand_vec();
  endtask

  // Full collection: start, beats (with optional gaps), DONE hold, ack.
  task automatic run_collect(input int vl_i, input logic [2:0] s, input logic msk,
      input logic vm_i, input logic [VLEN-1:0] v0, input logic [VLEN-1:0] vd,
      input int gap, input int ack_delay, input string name);
    int vle, nbeats;
    logic [VLEN-1:0] exp_img, hold;
    vle    = model_vl_eff(vl_i, s, msk);
    nbeats = (vle + LN - 1) / LN;
    exp_q.push_back(model_image(vl_i, s, msk, vm_i, v0, vd));
    do_start(vl_i, s, msk, vm_i, v0, vd);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    else n_pass++;
    for (int b = 0; b < nbeats; b++) begin
      n_checks++;
      if (elem_idx !== 32'(b*LN) || in_ready !== 1'b1 || out_valid !== 1'b0)
        $display("FAIL %s beat%0d_pre: got idx=%0d rdy=%b ov=%b want idx=%0d rdy=1 ov=0",
                 name, b, elem_idx, in_ready, out_valid, b*LN);
      else n_pass++;
      in_valid  = 1'b1;
      in_result = {res[b*LN+1], res[b*LN]};
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_result = {$urandom, $urandom, $urandom, $urandom};
      if (b != nbeats - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          n_checks++;
          if (elem_idx !== 32'((b+1)*LN) || out_valid !== 1'b0)
            $display("FAIL %s gap_stall: got idx=%0d ov=%b want idx=%0d ov=0",
                     name, elem_idx, out_valid, (b+1)*LN);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || elem_idx !== 32'(nbeats*LN))
      $display("FAIL %s done_state: got ov=%b rdy=%b idx=%0d want ov=1 rdy=0 idx=%0d",
               name, out_valid, in_ready, elem_idx, nbeats*LN);
    else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard: got empty queue want one entry", name);
    end else begin
      exp_img = exp_q.pop_front();
      if (out_data !== exp_img)
        $display("FAIL %s out_data: got %h want %h", name, out_data, exp_img);
      else n_pass++;
    end
    hold = out_data;
    for (int d = 0; d < ack_delay; d++) begin
      start = (d == 0);
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== hold || state_dbg !== 2'd2)
        $display("FAIL %s hold_until_ack: got ov=%b st=%0d data_changed=%b want ov=1 st=2 data_changed=0",
                 name, out_valid, state_dbg, out_data !== hold);
      else n_pass++;
    end
    out_ack = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    out_ack = 1'b0;
    start   = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== hold)
      $display("FAIL %s after_ack: got busy=%b ov=%b data_changed=%b want busy=0 ov=0 data_changed=0",
               name, busy, out_valid, out_data !== hold);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        elem_idx !== 32'd0 || out_data !== '0 || state_dbg !== 2'd0)
      $display("FAIL reset_state: got rdy=%b busy=%b ov=%b idx=%0d data_nz=%b st=%0d want all 0",
               in_ready, busy, out_valid, elem_idx, out_data != '0, state_dbg);
    else n_pass++;
  endtask

  task automatic test_unmasked_bytes();
    fill_random_res();
    for (int e = 0; e < 65; e++) res[e][7:0] = 8'(e + 1);
    run_collect(5, 3'd0, 1'b0, 1'b1, rand_vec(), {VLEN{1'b1}}, 0, 0, "unmasked_bytes");
    n_checks++;
    if (out_data[39:0] !== 40'h05_0403_0201 || out_data[VLEN-1:40] !== {(VLEN-40){1'b1}})
      $display("FAIL unmasked_bytes_const: got low=%h want low=0504030201 upper all ones",
               out_data[39:0]);
    else n_pass++;
  endtask

  task automatic test_masked_dwords();
    fill_random_res();
    for (int e = 0; e < 65; e++) res[e] = 64'(e + 1);
    run_collect(8, 3'd3, 1'b0, 1'b0, 512'hAA, {8{64'hAAAA_AAAA_AAAA_AAAA}}, 0, 1, "masked_dwords");
    n_checks++;
    if (out_data[127:64] !== 64'd2 || out_data[63:0] !== 64'hAAAA_AAAA_AAAA_AAAA ||
        out_data[511:448] !== 64'd8)
      $display("FAIL masked_dwords_const: got e0=%h e1=%h e7=%h want AAAA... 2 8",
               out_data[63:0], out_data[127:64], out_data[511:448]);
    else n_pass++;
  endtask

  task automatic test_mask_op();
    logic [VLEN-1:0] vd;
    vd = rand_vec();
    fill_random_res();
    for (int e = 0; e < 65; e++) res[e][0] = ((e % 2) == 0);
    run_collect(10, 3'd1, 1'b1, 1'b1, rand_vec(), vd, 0, 0, "mask_op");
    n_checks++;
    if (out_data[9:0] !== 10'h155 || out_data[VLEN-1:10] !== vd[VLEN-1:10])
      $display("FAIL mask_op_const: got low=%h want low=155 and upper bits of vd_old",
               out_data[9:0]);
    else n_pass++;
  endtask

  task automatic test_zero_and_clamp();
    logic [VLEN-1:0] vd;
    vd = rand_vec();
    fill_random_res();
    run_collect(0, 3'd2, 1'b0, 1'b1, rand_vec(), vd, 0, 2, "zero_length");
    n_checks++;
    if (out_data !== vd) $display("FAIL zero_length_vd: got %h want %h", out_data, vd);
    else n_pass++;
    fill_random_res();
    run_collect(100, 3'd2, 1'b0, 1'b1, rand_vec(), rand_vec(), 0, 0, "clamp_four_byte");
  endtask

  task automatic test_handshake();
    fill_random_res();
    run_collect(7, 3'd1, 1'b0, 1'b0, rand_vec(), rand_vec(), 2, 3, "handshake");
  endtask

  task automatic test_back_to_back();
    fill_random_res();
    run_collect(8, 3'b101, 1'b0, 1'b0, rand_vec(), rand_vec(), 0, 0, "unknown_sew");
    fill_random_res();
    run_collect(20, 3'd1, 1'b0, 1'b0, rand_vec(), rand_vec(),
                $urandom_range(0, 1), $urandom_range(0, 2), "b2b_half");
    fill_random_res();
    run_collect(70, 3'd0, 1'b0, 1'b1, rand_vec(), rand_vec(), 0, 0, "clamp_bytes");
  endtask

  task automatic test_reset_mid_collect();
    fill_random_res();
    do_start(8, 3'd0, 1'b0, 1'b1, rand_vec(), rand_vec());
    for (int b = 0; b < 2; b++) begin
      in_valid  = 1'b1;
      in_result = {res[2*b+1], res[2*b]};
      @(posedge clk); #1;
      in_valid  = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        elem_idx !== 32'd0 || out_data !== '0)
      $display("FAIL reset_mid_collect: got rdy=%b busy=%b ov=%b idx=%0d data_nz=%b want all 0",
               in_ready, busy, out_valid, elem_idx, out_data != '0);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random_res();
    run_collect(9, 3'd0, 1'b0, 1'b0, rand_vec(), rand_vec(), 1, 1, "after_reset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; start = 1'b0; vl = '0; vsew = '0; is_mask_operation = 1'b0;
    vm = 1'b1; v0_mask = '0; vd_old = '0; in_valid = 1'b0; in_result = '0; out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_unmasked_bytes();
    test_masked_dwords();
    test_mask_op();
    test_zero_and_clamp();
    test_handshake();
    test_back_to_back();
    test_reset_mid_collect();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
